// File: rtl/alu_issue_ctrl_if.sv
// Bundles the instruction handshake, register-file and ALU connections of the issue controller.
// The master modport is the issue controller. The slave modport is the fetch/regfile/ALU side.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] rf_raddr_a;
    logic [ADDR_W-1:0] rf_raddr_b;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_overflow;
    logic              busy;
    logic              illegal_op;
    logic              div_by_zero;

    modport master (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result, alu_overflow,
        output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_ctrl, busy, illegal_op, div_by_zero
    );

    modport slave (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result, alu_overflow,
        input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_ctrl, busy, illegal_op, div_by_zero
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit ALU. It accepts one instruction at a time, reads the operands,
// runs the ALU, and writes one or two results back to the register file.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int HI_REG = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WB_LO = 3'd3,
        WB_HI = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [2:0]        op_q;
    logic [3:0]        rd_q;
    logic [3:0]        rs_q;
    logic [3:0]        rt_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res_lo;
    logic [DATA_W-1:0] res_hi;
    logic              div_zero;
    logic              two_results;

    assign two_results = (op_q == 3'b010) || (op_q == 3'b011);

    always_comb begin
        next_state       = state;
        div_zero         = 1'b0;
        bus.instr_ready  = 1'b0;
        bus.busy         = (state != IDLE);
        bus.rf_raddr_a   = '0;
        bus.rf_raddr_b   = '0;
        bus.rf_we        = 1'b0;
        bus.rf_waddr     = '0;
        bus.rf_wdata     = '0;
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        bus.alu_ctrl     = 3'b111;
        bus.illegal_op   = 1'b0;
        bus.div_by_zero  = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    next_state = READ;
                end
            end
            READ: begin
                bus.rf_raddr_a = ADDR_W'(rs_q);
                bus.rf_raddr_b = ADDR_W'(rt_q);
                if (op_q[2:1] == 2'b11) begin
                    bus.illegal_op = 1'b1;
                    next_state     = IDLE;
                end else if ((op_q == 3'b011) && (bus.rf_rdata_b == '0)) begin
                    // Division by zero bypasses the ALU and writes a saturated result instead.
                    div_zero        = 1'b1;
                    bus.div_by_zero = 1'b1;
                    next_state      = WB_LO;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                bus.alu_a    = op_a;
                bus.alu_b    = op_b;
                bus.alu_ctrl = op_q;
                next_state   = WB_LO;
            end
            WB_LO: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = ADDR_W'(rd_q);
                bus.rf_wdata = res_lo;
                next_state   = two_results ? WB_HI : IDLE;
            end
            WB_HI: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = ADDR_W'(HI_REG);
                bus.rf_wdata = res_hi;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers. A reset clears them, so an instruction that is in flight at reset is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rd_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            res_lo <= '0;
            res_hi <= '0;
        end else begin
            if ((state == IDLE) && bus.instr_valid) begin
                op_q <= bus.instr[15:13];
                rd_q <= bus.instr[11:8];
                rs_q <= bus.instr[7:4];
                rt_q <= bus.instr[3:0];
            end
            if (state == READ) begin
                op_a <= bus.rf_rdata_a;
                op_b <= bus.rf_rdata_b;
                if (div_zero) begin
                    res_lo <= '1;
                    res_hi <= bus.rf_rdata_a;
                end
            end
            if (state == EXEC) begin
                res_lo <= bus.alu_result;
                res_hi <= bus.alu_overflow;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl. It models the register file and the ALU around the DUT.
// It predicts each write-back and compares it when the DUT writes.
module tb_alu_issue_ctrl;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] rf [16];
    logic [15:0] model_rf [16];
    wr_t         exp_q [$];
    int          cyc;
    int          accept_cyc;
    int          checks;
    int          errors;
    int          dbz_alu_hits;
    int          overlap_hits;
    logic [31:0] alu_prod;

    alu_issue_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    alu_issue_ctrl #(.DATA_W(16), .ADDR_W(4), .HI_REG(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
    assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

    // Behavioural ALU that stands in for the real one.
    always_comb begin
        alu_prod         = 32'(bus.alu_a) * 32'(bus.alu_b);
        bus.alu_result   = '0;
        bus.alu_overflow = '0;
        case (bus.alu_ctrl)
            3'b000: bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001: bus.alu_result = bus.alu_a - bus.alu_b;
            3'b010: begin
                bus.alu_result   = alu_prod[15:0];
                bus.alu_overflow = alu_prod[31:16];
            end
            3'b011: begin
                if (bus.alu_b != '0) begin
                    bus.alu_result   = bus.alu_a / bus.alu_b;
                    bus.alu_overflow = bus.alu_a % bus.alu_b;
                end
            end
            3'b100: bus.alu_result = bus.alu_a & bus.alu_b;
            3'b101: bus.alu_result = bus.alu_a | bus.alu_b;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rf_we) begin
            rf[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write-back monitor. It pops the oldest prediction for every rf_we it sees.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.alu_ctrl == 3'b011 && bus.alu_b == '0) dbz_alu_hits++;
            if (bus.illegal_op && bus.div_by_zero) overlap_hits++;
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_we", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    checkOutput("wb_addr", 32'(bus.rf_waddr), 32'(e.addr));
                    checkOutput("wb_data", 32'(bus.rf_wdata), 32'(e.data));
                    checkOutput("wb_cycle", 32'(cyc - accept_cyc + 1), 32'(e.cyc));
                end
            end
        end
    end

    task automatic setReg(input int idx, input logic [15:0] val);
        rf[idx]       <= val;
        model_rf[idx] =  val;
    endtask

    task automatic applyStimulus(input logic [15:0] ins);
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        ill;
        logic        dbz;
        logic        two;
        int          lo_cyc;
        int          ready_cyc;
        int          waited;
        int          k;
        op  = ins[15:13];
        rd  = ins[11:8];
        a   = model_rf[ins[7:4]];
        b   = model_rf[ins[3:0]];
        p   = 32'(a) * 32'(b);
        ill = (op[2:1] == 2'b11);
        dbz = (op == 3'b011) && (b == 16'h0000);
        two = (op == 3'b010) || (op == 3'b011);
        lo  = 16'h0000;
        hi  = 16'h0000;
        case (op)
            3'b000: lo = a + b;
            3'b001: lo = a - b;
            3'b010: begin lo = p[15:0]; hi = p[31:16]; end
            3'b011: begin
                if (dbz) begin lo = 16'hFFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            3'b100: lo = a & b;
            3'b101: lo = a | b;
            default: ;
        endcase
        lo_cyc    = dbz ? 2 : 3;
        ready_cyc = ill ? 2 : (dbz ? 4 : (two ? 5 : 4));

        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        waited = 0;
        while (!bus.instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.instr_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        accept_cyc = cyc + 1;
        if (!ill) begin
            exp_q.push_back('{addr: rd, data: lo, cyc: lo_cyc});
            model_rf[rd] = lo;
            if (two) begin
                exp_q.push_back('{addr: 4'd15, data: hi, cyc: lo_cyc + 1});
                model_rf[15] = hi;
            end
        end

        @(negedge clk);
        bus.instr_valid = 1'b0;
        checkOutput("illegal_op", 32'(bus.illegal_op), 32'(ill));
        checkOutput("div_by_zero", 32'(bus.div_by_zero), 32'(dbz));
        checkOutput("busy_c1", 32'(bus.busy), 32'd1);
        k = 1;
        if (!ill) begin
            @(negedge clk);
            k = 2;
            checkOutput("exec_ctrl", 32'(bus.alu_ctrl), dbz ? 32'd7 : 32'(op));
            if (!dbz) begin
                checkOutput("exec_a", 32'(bus.alu_a), 32'(a));
                checkOutput("exec_b", 32'(bus.alu_b), 32'(b));
            end
        end
        while (!bus.instr_ready && k < 12) begin
            @(negedge clk);
            k++;
        end
        checkOutput("ready_cycle", 32'(k), 32'(ready_cyc));
        checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        cyc             = 0;
        accept_cyc      = 0;
        checks          = 0;
        errors          = 0;
        dbz_alu_hits    = 0;
        overlap_hits    = 0;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        for (int i = 0; i < 16; i++) setReg(i, 16'(i * 16'h0101));

        repeat (2) @(negedge clk);
        checkOutput("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd7);
        checkOutput("rst_rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("rst_wdata", 32'(bus.rf_wdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", 32'(bus.instr_ready), 32'd1);

        setReg(1, 16'd5);
        setReg(2, 16'd7);
        applyStimulus(16'h0312);
        checkOutput("add_r3", 32'(rf[3]), 32'h000C);

        setReg(1, 16'd3);
        setReg(2, 16'd5);
        applyStimulus(16'h2312);
        checkOutput("sub_r3", 32'(rf[3]), 32'hFFFE);

        setReg(6, 16'h1234);
        setReg(7, 16'h0100);
        applyStimulus(16'h4467);
        checkOutput("mul_r4", 32'(rf[4]), 32'h3400);
        checkOutput("mul_r15", 32'(rf[15]), 32'h0012);

        setReg(8, 16'd100);
        setReg(9, 16'd7);
        applyStimulus(16'h6589);
        checkOutput("div_r5", 32'(rf[5]), 32'h000E);
        checkOutput("div_r15", 32'(rf[15]), 32'h0002);

        setReg(10, 16'h00AB);
        setReg(11, 16'h0000);
        applyStimulus(16'h65AB);
        checkOutput("dbz_r5", 32'(rf[5]), 32'hFFFF);
        checkOutput("dbz_r15", 32'(rf[15]), 32'h00AB);

        applyStimulus(16'hC312);
        applyStimulus(16'hE312);
        applyStimulus(16'h8312);
        applyStimulus(16'hA312);
        applyStimulus(16'h0311);
        applyStimulus(16'h4F67);
        checkOutput("hi_wins_r15", 32'(rf[15]), 32'h0012);

        // The reset arrives while the ADD is in EXEC, so no write-back may follow.
        setReg(6, 16'h5A5A);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h0612;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_exec_ctrl", 32'(bus.alu_ctrl), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mid_we", 32'(bus.rf_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
        checkOutput("rst_mid_r6", 32'(rf[6]), 32'h5A5A);
        applyStimulus(16'h0312);

        for (int i = 0; i < 16; i++) setReg(i, 16'($urandom));
        for (int i = 0; i < 24; i++) applyStimulus(16'($urandom));

        for (int i = 0; i < 16; i++) checkOutput($sformatf("rf_final_%0d", i), 32'(rf[i]), 32'(model_rf[i]));
        checkOutput("dbz_alu_div", 32'(dbz_alu_hits), 32'd0);
        checkOutput("flag_overlap", 32'(overlap_hits), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
